song_step_sequencer: RTL and testbench
======================================

Name: song_step_sequencer

Overview:
- Table-driven replacement for hard-coded song FSMs. Plays a programmable list of note steps and drives the tone selector's bass select, high select and mixer controls.
- Each step holds a bass code, a high code, a mixer bit and a duration in tempo ticks.
- When song mode is off, the manual switch/key controls pass through to the same outputs. The tone selector is therefore fed from one source only.

Parameters:
- STEPS, 16, number of step entries; power of two.
- IDX_W, 4, log2(STEPS).
- DUR_W, 8, duration field width in tempo ticks.
- TICK_DIV, 500000, clk cycles per tempo tick (10 ms at 50 MHz); ≥2.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  song mode switch; 0 selects manual pass-through.
- start_n  in  1  active-low start key, already synchronised; a 1→0 edge starts play.
- stop  in  1  level; aborts play.
- loop_en  in  1  1 restarts at step 0 after the last step.
- man_bass  in  3  manual bass select.
- man_hi  in  3  manual high select.
- man_mixer  in  1  manual mixer select.
- wr_en  in  1  step table write strobe.
- wr_addr  in  IDX_W  step index to write.
- wr_data  in  7+DUR_W  entry fields: {bass[2:0], hi[2:0], mixer, dur}, with bass in the MSBs.
- bass_sel  out  3  to the tone selector bass switches.
- hi_sel  out  3  to the tone selector high switches.
- mixer_sel  out  1  to the tone selector mixer.
- playing  out  1  high in LOAD and PLAY.
- step_idx  out  IDX_W  current step index.
- step_strobe  out  1  one-cycle pulse in the first PLAY cycle of each step.
- done  out  1  one-cycle pulse when a non-looping song ends.

Behaviour:
- Reset: state IDLE; all outputs 0; step table cleared to zero; start edge detector preloaded to 1, so no false edge occurs at reset release.
- States: IDLE, LOAD, PLAY.
- IDLE:
  - Outputs are registered with 1-cycle latency.
  - enable=0: bass_sel/hi_sel/mixer_sel follow man_bass/man_hi/man_mixer.
  - enable=1: outputs are bass=0, hi=0, mixer=1.
  - A start_n falling edge with enable=1 and stop=0 → LOAD, step_idx=0.
- LOAD (1 cycle): latch table[step_idx] into the entry register.
  - dur≠0 → PLAY. Outputs take the latched bass/hi/mixer on the edge leaving LOAD. The tick counter and duration counter clear.
  - dur=0 is the end marker and is treated as end-of-song (see below).
- PLAY:
  - The tick counter counts 0..TICK_DIV-1. On wrap, the duration counter increments.
  - When the duration counter reaches dur at a tick wrap, the step ends. PLAY therefore lasts exactly dur*TICK_DIV cycles.
  - If step_idx≠STEPS-1: step_idx+1, go to LOAD.
  - If step_idx=STEPS-1: end-of-song.
- End-of-song:
  - loop_en=1: step_idx=0 → LOAD.
  - loop_en=0: → IDLE with a done pulse.
  - If step 0 is itself the end marker, go to IDLE with a done pulse even if loop_en=1, so no zero-length loop occurs.
- Step period = dur*TICK_DIV + 1 cycles.
- Abort: stop=1 or enable=0 in LOAD/PLAY → IDLE on the next edge. Counters clear, no done pulse, and IDLE output rules apply from the following cycle.
- Table writes:
  - Synchronous, allowed in any state.
  - A write to the currently playing index does not affect the latched entry; it takes effect the next time that index is loaded.
- Simultaneous events:
  - A write to the index being read in LOAD on the same cycle: LOAD latches the old contents.
  - stop wins over a start edge.
  - A start edge while already playing is ignored.
- step_idx holds its last value in IDLE until the next start.

Decomposition:
- Shared package song_pkg:
  - state enum;
  - entry field offsets/widths: BASS_MSB, HI_MSB, MIX_BIT, DUR_LSB;
  - idle-song constants BASS_IDLE=0, HI_IDLE=0, MIX_IDLE=1;
  - note code constants matching the tone selector (e.g. 3'b100, 3'b011, 3'b001, 3'b110).
- One sub-module, tempo_tick: free-running prescaler with clear input and one-cycle tick output at count TICK_DIV-1.

Test Plan:
All scenarios use TICK_DIV=4.
- Manual pass-through: enable=0, man_bass=5, man_hi=2, man_mixer=1 → outputs 5/2/1 one cycle later; playing=0.
- Basic play:
  - Stimulus: load step0={4,3,0,dur=2}, step1={3,1,0,dur=1}, step2 dur=0; enable=1, loop_en=0; pulse start_n.
  - Required response: step0 outputs 4/3/0 for 8 cycles, then after 1 LOAD cycle 3/1/0 for 4 cycles. Then done pulses once, and outputs return to 0/0/1. step_strobe pulses twice.
- Loop: same table with loop_en=1 → after step1, step_idx=0 and outputs 4/3/0 again; no done pulse.
- Abort: stop=1 mid-step0 → IDLE next edge, playing=0, no done; a new start_n edge restarts at step 0 with full duration.
- Full table wrap: all 16 steps dur=1, loop_en=0 → 16 strobes; done fires after step 15, 16*5 cycles after start.
- Edge cases:
  - Write step1 while step1 plays → the current step keeps its old codes; the next loop plays the new codes.
  - Step 0 dur=0 with loop_en=1 → done pulse, return to IDLE.
  - Reset asserted mid-PLAY → all outputs 0 immediately.

Source files
------------

// File: rtl/song_pkg.sv
`default_nettype none
//==============================================================================
// Module   : song_pkg
// Desc     : Shared states, step-entry layout and tone codes for the sequencer.
// Revision : 1.0 - initial release
//==============================================================================
package song_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_LOAD = 2'd1;
    localparam state_t c_ST_PLAY = 2'd2;

    // Entry layout: {bass[2:0], hi[2:0], mixer, dur[DUR_W-1:0]}
    localparam int c_DUR_LSB = 0;

    function automatic int mix_bit(input int dur_w);
        return dur_w;
    endfunction

    function automatic int hi_msb(input int dur_w);
        return dur_w + 3;
    endfunction

    function automatic int bass_msb(input int dur_w);
        return dur_w + 6;
    endfunction

    localparam logic [2:0] c_BASS_IDLE = 3'd0;
    localparam logic [2:0] c_HI_IDLE   = 3'd0;
    localparam logic       c_MIX_IDLE  = 1'b1;

    // Switch codes understood by the tone selector
    localparam logic [2:0] c_NOTE_A = 3'b100;
    localparam logic [2:0] c_NOTE_B = 3'b011;
    localparam logic [2:0] c_NOTE_C = 3'b001;
    localparam logic [2:0] c_NOTE_D = 3'b110;

endpackage
`default_nettype wire

// File: rtl/tempo_tick.sv
`default_nettype none
//==============================================================================
// Module   : tempo_tick
// Desc     : Free-running prescaler; one-cycle tick at count TICK_DIV-1.
// Revision : 1.0 - initial release
//==============================================================================
module tempo_tick #(
    parameter int TICK_DIV = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int                c_CNT_W = $clog2(TICK_DIV);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TICK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == c_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign tick = ~clr & (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/song_step_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : song_step_sequencer
// Desc     : Plays a programmable step table onto the tone selector controls,
//            with manual switch pass-through when song mode is off.
// Revision : 1.0 - initial release
//==============================================================================
module song_step_sequencer
    import song_pkg::*;
#(
    parameter int STEPS    = 16,
    parameter int IDX_W    = 4,
    parameter int DUR_W    = 8,
    parameter int TICK_DIV = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             start_n,
    input  logic             stop,
    input  logic             loop_en,
    input  logic [2:0]       man_bass,
    input  logic [2:0]       man_hi,
    input  logic             man_mixer,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [DUR_W+6:0] wr_data,
    output logic [2:0]       bass_sel,
    output logic [2:0]       hi_sel,
    output logic             mixer_sel,
    output logic             playing,
    output logic [IDX_W-1:0] step_idx,
    output logic             step_strobe,
    output logic             done
);

    localparam int c_ENT_W    = DUR_W + 7;
    localparam int c_MIX_BIT  = mix_bit(DUR_W);
    localparam int c_HI_MSB   = hi_msb(DUR_W);
    localparam int c_BASS_MSB = bass_msb(DUR_W);

    state_t             r_state,    w_state_nxt;
    logic [IDX_W-1:0]   r_step_idx, w_step_idx_nxt;
    logic [DUR_W-1:0]   r_dur,      w_dur_nxt;
    logic [DUR_W-1:0]   r_dur_cnt,  w_dur_cnt_nxt;
    logic [2:0]         r_bass,     w_bass_nxt;
    logic [2:0]         r_hi,       w_hi_nxt;
    logic               r_mix,      w_mix_nxt;
    logic               r_strobe,   w_strobe_nxt;
    logic               r_done,     w_done_nxt;
    logic               r_start_d;
    logic [c_ENT_W-1:0] r_table [STEPS];

    logic [c_ENT_W-1:0] w_rd;
    logic [DUR_W-1:0]   w_rd_dur;
    logic               w_start_edge;
    logic               w_abort;
    logic               w_last;
    logic               w_tick;
    logic               w_tick_clr;

    assign w_rd         = r_table[r_step_idx];
    assign w_rd_dur     = w_rd[c_DUR_LSB +: DUR_W];
    assign w_start_edge = r_start_d & ~start_n;
    assign w_abort      = stop | ~enable;
    assign w_last       = (r_step_idx == IDX_W'(STEPS - 1));
    assign w_tick_clr   = (r_state != c_ST_PLAY);

    tempo_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tempo_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_tick_clr),
        .tick (w_tick)
    );

    // Table write port; LOAD reads combinationally, so a same-cycle write is seen next load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STEPS; i++) begin
                r_table[i] <= '0;
            end
        end else if (wr_en) begin
            r_table[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_ST_IDLE;
            r_step_idx <= '0;
            r_dur      <= '0;
            r_dur_cnt  <= '0;
            r_bass     <= '0;
            r_hi       <= '0;
            r_mix      <= 1'b0;
            r_strobe   <= 1'b0;
            r_done     <= 1'b0;
            r_start_d  <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_step_idx <= w_step_idx_nxt;
            r_dur      <= w_dur_nxt;
            r_dur_cnt  <= w_dur_cnt_nxt;
            r_bass     <= w_bass_nxt;
            r_hi       <= w_hi_nxt;
            r_mix      <= w_mix_nxt;
            r_strobe   <= w_strobe_nxt;
            r_done     <= w_done_nxt;
            r_start_d  <= start_n;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_step_idx_nxt = r_step_idx;
        w_dur_nxt      = r_dur;
        w_dur_cnt_nxt  = r_dur_cnt;
        w_bass_nxt     = r_bass;
        w_hi_nxt       = r_hi;
        w_mix_nxt      = r_mix;
        w_strobe_nxt   = 1'b0;
        w_done_nxt     = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (enable) begin
                    w_bass_nxt = c_BASS_IDLE;
                    w_hi_nxt   = c_HI_IDLE;
                    w_mix_nxt  = c_MIX_IDLE;
                end else begin
                    w_bass_nxt = man_bass;
                    w_hi_nxt   = man_hi;
                    w_mix_nxt  = man_mixer;
                end
                if (w_start_edge && enable && !stop) begin
                    w_state_nxt    = c_ST_LOAD;
                    w_step_idx_nxt = '0;
                end
            end

            c_ST_LOAD: begin
                if (w_abort) begin
                    w_state_nxt   = c_ST_IDLE;
                    w_dur_cnt_nxt = '0;
                end else if (w_rd_dur != '0) begin
                    w_state_nxt   = c_ST_PLAY;
                    w_dur_nxt     = w_rd_dur;
                    w_dur_cnt_nxt = '0;
                    w_bass_nxt    = w_rd[c_BASS_MSB -: 3];
                    w_hi_nxt      = w_rd[c_HI_MSB -: 3];
                    w_mix_nxt     = w_rd[c_MIX_BIT];
                    w_strobe_nxt  = 1'b1;
                end else if ((r_step_idx == '0) || !loop_en) begin
                    // End marker; an empty step 0 never loops
                    w_state_nxt = c_ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_step_idx_nxt = '0;
                end
            end

            c_ST_PLAY: begin
                if (w_abort) begin
                    w_state_nxt   = c_ST_IDLE;
                    w_dur_cnt_nxt = '0;
                end else if (w_tick) begin
                    if ((r_dur_cnt + DUR_W'(1)) == r_dur) begin
                        w_dur_cnt_nxt = '0;
                        if (!w_last) begin
                            w_step_idx_nxt = r_step_idx + IDX_W'(1);
                            w_state_nxt    = c_ST_LOAD;
                        end else if (loop_en) begin
                            w_step_idx_nxt = '0;
                            w_state_nxt    = c_ST_LOAD;
                        end else begin
                            w_state_nxt = c_ST_IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_dur_cnt_nxt = r_dur_cnt + DUR_W'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign bass_sel    = r_bass;
    assign hi_sel      = r_hi;
    assign mixer_sel   = r_mix;
    assign playing     = (r_state != c_ST_IDLE);
    assign step_idx    = r_step_idx;
    assign step_strobe = r_strobe;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_song_step_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : tb_song_step_sequencer
// Desc     : Self-checking bench: manual vector table, song schedules from a
//            step-list model, corner sequences and randomized songs.
// Revision : 1.0 - initial release
//==============================================================================
module tb_song_step_sequencer;

    localparam int STEPS    = 16;
    localparam int IDX_W    = 4;
    localparam int DUR_W    = 8;
    localparam int TICK_DIV = 4;
    localparam int EW       = DUR_W + 7;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             enable = 1'b0;
    logic             start_n = 1'b1;
    logic             stop = 1'b0;
    logic             loop_en = 1'b0;
    logic [2:0]       man_bass = '0;
    logic [2:0]       man_hi = '0;
    logic             man_mixer = 1'b0;
    logic             wr_en = 1'b0;
    logic [IDX_W-1:0] wr_addr = '0;
    logic [EW-1:0]    wr_data = '0;
    logic [2:0]       bass_sel;
    logic [2:0]       hi_sel;
    logic             mixer_sel;
    logic             playing;
    logic [IDX_W-1:0] step_idx;
    logic             step_strobe;
    logic             done;

    song_step_sequencer #(
        .STEPS    (STEPS),
        .IDX_W    (IDX_W),
        .DUR_W    (DUR_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .start_n     (start_n),
        .stop        (stop),
        .loop_en     (loop_en),
        .man_bass    (man_bass),
        .man_hi      (man_hi),
        .man_mixer   (man_mixer),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .bass_sel    (bass_sel),
        .hi_sel      (hi_sel),
        .mixer_sel   (mixer_sel),
        .playing     (playing),
        .step_idx    (step_idx),
        .step_strobe (step_strobe),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]       bass;
        logic [2:0]       hi;
        logic             mix;
        logic             playing;
        logic [IDX_W-1:0] idx;
        logic             strobe;
        logic             done;
    } obs_t;

    typedef struct {
        logic       en;
        logic [2:0] mb;
        logic [2:0] mh;
        logic       mm;
        logic [2:0] eb;
        logic [2:0] eh;
        logic       em;
    } vec_t;

    obs_t          exp_q[$];
    logic [EW-1:0] m_tab [STEPS];
    int            errors = 0;
    int            checks = 0;

    function automatic obs_t sample();
        obs_t o;
        o.bass    = bass_sel;
        o.hi      = hi_sel;
        o.mix     = mixer_sel;
        o.playing = playing;
        o.idx     = step_idx;
        o.strobe  = step_strobe;
        o.done    = done;
        return o;
    endfunction

    function automatic logic [EW-1:0] ent(input int b, input int h, input int m, input int d);
        return {b[2:0], h[2:0], m[0], d[7:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_obs(input string name, input int k, input obs_t e);
        obs_t a;
        a = sample();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s[%0d]: got b/h/m=%0d/%0d/%0d play=%0d idx=%0d stb=%0d done=%0d, want b/h/m=%0d/%0d/%0d play=%0d idx=%0d stb=%0d done=%0d",
                     name, k, a.bass, a.hi, a.mix, a.playing, a.idx, a.strobe, a.done,
                     e.bass, e.hi, e.mix, e.playing, e.idx, e.strobe, e.done);
        end
    endtask

    task automatic check_val(input string name, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, a, e);
        end
    endtask

    task automatic tab_wr(input int a, input logic [EW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = IDX_W'(a);
        wr_data = d;
        step();
        wr_en   = 1'b0;
        m_tab[a] = d;
    endtask

    task automatic settle();
        wr_en   = 1'b0;
        stop    = 1'b0;
        enable  = 1'b1;
        start_n = 1'b1;
        step();
        step();
    endtask

    // Expected per-cycle trace after the start edge, built from the step list:
    // one LOAD cycle per visited entry, then dur*TICK_DIV cycles showing its codes.
    task automatic build_trace(input int wr_at, input int wr_a, input logic [EW-1:0] wr_d,
                               input int abort_at, input bit by_en, output bit eff_abort);
        obs_t          o;
        logic [2:0]    pb;
        logic [2:0]    ph;
        logic          pm;
        logic [EW-1:0] t;
        int            i;
        int            d;
        int            lim;
        bit            ended;
        pb = 3'd0; ph = 3'd0; pm = 1'b1; i = 0; ended = 1'b0;
        exp_q.delete();
        lim = (abort_at >= 0) ? abort_at + 1 : 4000;
        while (!ended && exp_q.size() < lim) begin
            t = (wr_at >= 0 && exp_q.size() > wr_at && i == wr_a) ? wr_d : m_tab[i];
            exp_q.push_back('{pb, ph, pm, 1'b1, IDX_W'(i), 1'b0, 1'b0});
            d = int'(t[7:0]);
            if (d == 0) begin
                if (i == 0 || !loop_en) ended = 1'b1;
                else i = 0;
            end else begin
                for (int k = 0; k < d * TICK_DIV; k++)
                    exp_q.push_back('{t[14:12], t[11:9], t[8], 1'b1, IDX_W'(i), (k == 0), 1'b0});
                pb = t[14:12]; ph = t[11:9]; pm = t[8];
                if (i == STEPS - 1) begin
                    if (loop_en) i = 0;
                    else ended = 1'b1;
                end else begin
                    i++;
                end
            end
        end
        eff_abort = (abort_at >= 0) && (exp_q.size() > abort_at);
        if (eff_abort) begin
            while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
            o = exp_q[abort_at];
            o.playing = 1'b0;
            o.strobe  = 1'b0;
            exp_q.push_back(o);
            if (by_en) exp_q.push_back('{man_bass, man_hi, man_mixer, 1'b0, o.idx, 1'b0, 1'b0});
            else       exp_q.push_back('{3'd0, 3'd0, 1'b1, 1'b0, o.idx, 1'b0, 1'b0});
        end else begin
            exp_q.push_back('{pb, ph, pm, 1'b0, IDX_W'(i), 1'b0, 1'b1});
            exp_q.push_back('{3'd0, 3'd0, 1'b1, 1'b0, IDX_W'(i), 1'b0, 1'b0});
        end
    endtask

    task automatic run_trace(input string name, input int wr_at, input int wr_a,
                             input logic [EW-1:0] wr_d, input int abort_at, input bit by_en,
                             output int strobes, output int dones, output int done_at);
        bit ea;
        int n;
        build_trace(wr_at, wr_a, wr_d, abort_at, by_en, ea);
        n = exp_q.size();
        strobes = 0; dones = 0; done_at = -1;
        start_n = 1'b0;
        for (int k = 0; k < n; k++) begin
            step();
            check_obs(name, k, exp_q[k]);
            if (step_strobe) strobes++;
            if (done) begin
                dones++;
                if (done_at < 0) done_at = k;
            end
            wr_en   = (k == wr_at);
            wr_addr = IDX_W'(wr_a);
            wr_data = wr_d;
            stop    = ea && !by_en && (k == abort_at);
            if (ea && by_en && k == abort_at) enable = 1'b0;
            start_n = (k < n - 4) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (wr_at >= 0 && wr_at < n - 1) m_tab[wr_a] = wr_d;
        settle();
    endtask

    vec_t vecs [6];
    int   s, dn, da;

    initial begin
        for (int a = 0; a < STEPS; a++) m_tab[a] = '0;
        vecs[0] = '{1'b0, 3'd5, 3'd2, 1'b1, 3'd5, 3'd2, 1'b1};
        vecs[1] = '{1'b0, 3'd7, 3'd7, 1'b0, 3'd7, 3'd7, 1'b0};
        vecs[2] = '{1'b1, 3'd5, 3'd2, 1'b1, 3'd0, 3'd0, 1'b1};
        vecs[3] = '{1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0};
        vecs[4] = '{1'b1, 3'd7, 3'd7, 1'b0, 3'd0, 3'd0, 1'b1};
        vecs[5] = '{1'b0, 3'd3, 3'd4, 1'b1, 3'd3, 3'd4, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check_obs("reset", 0, '0);
        rst = 1'b1;
        step();

        for (int v = 0; v < 6; v++) begin
            enable    = vecs[v].en;
            man_bass  = vecs[v].mb;
            man_hi    = vecs[v].mh;
            man_mixer = vecs[v].mm;
            step();
            check_obs("manual", v, '{vecs[v].eb, vecs[v].eh, vecs[v].em, 1'b0, IDX_W'(0), 1'b0, 1'b0});
        end
        settle();

        // Basic two-step song ending on an empty entry
        tab_wr(0, ent(4, 3, 0, 2));
        tab_wr(1, ent(3, 1, 0, 1));
        loop_en = 1'b0;
        run_trace("basic", -1, 0, '0, -1, 1'b0, s, dn, da);
        check_val("basic_strobes", s, 2);
        check_val("basic_dones", dn, 1);
        check_val("basic_done_at", da, 15);

        loop_en = 1'b1;
        run_trace("loop", -1, 0, '0, 40, 1'b0, s, dn, da);
        check_val("loop_dones", dn, 0);

        loop_en = 1'b0;
        run_trace("abort", -1, 0, '0, 4, 1'b0, s, dn, da);
        check_val("abort_dones", dn, 0);
        run_trace("restart", -1, 0, '0, -1, 1'b0, s, dn, da);
        check_val("restart_strobes", s, 2);

        stop    = 1'b1;
        start_n = 1'b0;
        step();
        check_val("stop_beats_start", int'(playing), 0);
        settle();

        loop_en = 1'b1;
        run_trace("wr_play", 10, 1, ent(6, 5, 1, 1), 40, 1'b0, s, dn, da);
        run_trace("wr_load", 9, 1, ent(2, 7, 0, 2), 45, 1'b0, s, dn, da);
        run_trace("en_abort", -1, 0, '0, 12, 1'b1, s, dn, da);

        loop_en = 1'b0;
        for (int a = 0; a < STEPS; a++) tab_wr(a, ent(a % 8, 7 - (a % 8), a % 2, 1));
        run_trace("wrap", -1, 0, '0, -1, 1'b0, s, dn, da);
        check_val("wrap_strobes", s, 16);
        check_val("wrap_done_at", da, 80);

        tab_wr(0, ent(5, 5, 1, 0));
        loop_en = 1'b1;
        run_trace("zero0", -1, 0, '0, -1, 1'b0, s, dn, da);
        check_val("zero0_done_at", da, 1);
        check_val("zero0_strobes", s, 0);

        for (int r = 0; r < 8; r++) begin
            int ab, wa;
            for (int a = 0; a < STEPS; a++)
                tab_wr(a, ent(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                              int'($urandom_range(0, 1)),
                              ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3))));
            loop_en   = 1'($urandom_range(0, 1));
            man_bass  = 3'($urandom_range(0, 7));
            man_hi    = 3'($urandom_range(0, 7));
            man_mixer = 1'($urandom_range(0, 1));
            ab = (loop_en || $urandom_range(0, 2) == 0) ? int'($urandom_range(0, 120)) : -1;
            wa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 60)) : -1;
            run_trace("rand", wa, int'($urandom_range(0, 15)),
                      ent(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 1)), int'($urandom_range(0, 3))),
                      ab, 1'($urandom_range(0, 1)), s, dn, da);
        end

        // Asynchronous reset in the middle of a step
        tab_wr(0, ent(4, 3, 0, 2));
        loop_en = 1'b1;
        start_n = 1'b0;
        step();
        start_n = 1'b1;
        repeat (4) step();
        check_val("pre_reset_bass", int'(bass_sel), 4);
        #2;
        rst = 1'b0;
        #1;
        check_obs("async_reset", 0, '0);
        @(negedge clk);
        rst = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
